// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader writing 9-bit words into the instruction RAM
// Optional feature macro: INST_LOADER_CHECKSUM_EN (trailing XOR checksum byte after the last word)
module inst_loader #(
   parameter int IW = 16
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          start,
   input  logic [7:0]    byte_in,
   input  logic          byte_valid,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [IW-1:0] mem_addr,
   output logic [8:0]    mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          cpu_hold
);

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_LEN_LO  = 4'd1;
   localparam logic [3:0] ST_LEN_HI  = 4'd2;
   localparam logic [3:0] ST_INST_LO = 4'd3;
   localparam logic [3:0] ST_INST_HI = 4'd4;
   localparam logic [3:0] ST_WRITE   = 4'd5;
   localparam logic [3:0] ST_CSUM    = 4'd6;
   localparam logic [3:0] ST_DONE    = 4'd7;
   localparam logic [3:0] ST_ERR     = 4'd8;

   // Largest legal word count: the whole RAM, saturating at what a 16-bit count can express.
   localparam logic [16:0] MAX_COUNT = (IW >= 16) ? 17'h10000 : 17'(1 << IW);

   logic [3:0]    state;
   logic [7:0]    countLo;
   logic [15:0]   remaining;
   logic [IW-1:0] addr;
   logic [7:0]    loByte;
   logic [IW-1:0] memAddrQ;
   logic [8:0]    memWdataQ;
   logic          xfer;
   logic [16:0]   countFull;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]    csumAcc;
`endif

   assign xfer      = byte_valid & byte_ready;
   assign countFull = {1'b0, byte_in, countLo};

   // Loader FSM plus the address, word-count and captured-word registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= ST_IDLE;
         countLo   <= 8'd0;
         remaining <= 16'd0;
         addr      <= '0;
         loByte    <= 8'd0;
         memAddrQ  <= '0;
         memWdataQ <= 9'd0;
`ifdef INST_LOADER_CHECKSUM_EN
         csumAcc   <= 8'd0;
`endif
      end else begin
`ifdef INST_LOADER_CHECKSUM_EN
         // Running XOR covers every stream byte before the checksum byte itself.
         if (xfer && state != ST_CSUM) begin
            csumAcc <= csumAcc ^ byte_in;
         end
`endif
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state <= ST_LEN_LO;
                  addr  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                  csumAcc <= 8'd0;
`endif
               end
            end
            ST_LEN_LO: begin
               if (xfer) begin
                  countLo <= byte_in;
                  state   <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (xfer) begin
                  remaining <= countFull[15:0];
                  if (countFull == 17'd0) begin
                     state <= ST_DONE;
                  end else if (countFull > MAX_COUNT) begin
                     state <= ST_ERR;
                  end else begin
                     state <= ST_INST_LO;
                  end
               end
            end
            ST_INST_LO: begin
               if (xfer) begin
                  loByte <= byte_in;
                  state  <= ST_INST_HI;
               end
            end
            ST_INST_HI: begin
               if (xfer) begin
                  if (byte_in[7:1] != 7'd0) begin
                     state <= ST_ERR;
                  end else begin
                     // Captured here so mem_addr/mem_wdata hold their value after the write.
                     memAddrQ  <= addr;
                     memWdataQ <= {byte_in[0], loByte};
                     state     <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               addr      <= addr + 1'b1;
               remaining <= remaining - 16'd1;
               if (remaining == 16'd1) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  state <= ST_CSUM;
`else
                  state <= ST_DONE;
`endif
               end else begin
                  state <= ST_INST_LO;
               end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (xfer) begin
                  state <= (byte_in == csumAcc) ? ST_DONE : ST_ERR;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from state so a reset mid-write drops mem_we immediately.
   always_comb begin
      byte_ready = 1'b0;
      case (state)
         ST_LEN_LO, ST_LEN_HI, ST_INST_LO, ST_INST_HI: byte_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
         ST_CSUM: byte_ready = 1'b1;
`endif
         default: byte_ready = 1'b0;
      endcase
   end

   assign mem_we    = (state == ST_WRITE);
   assign mem_addr  = memAddrQ;
   assign mem_wdata = memWdataQ;
   assign busy      = byte_ready | mem_we;
   assign cpu_hold  = busy;
   assign done      = (state == ST_DONE);
   assign error     = (state == ST_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader (IW=4 to reach the capacity limit)
module tb_inst_loader;

   localparam int IW = 4;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    byte_in = 8'd0;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic          mem_we;
   logic [IW-1:0] mem_addr;
   logic [8:0]    mem_wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic          cpu_hold;

   int   errors = 0;
   int   checks = 0;
   int   wAddr[$];
   int   wData[$];
   logic [7:0] csumAcc = 8'd0;

   inst_loader #(.IW(IW)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .error(error), .cpu_hold(cpu_hold)
   );

   always #5 CLK = ~CLK;

   // Record every RAM write, sampled mid-cycle.
   always @(negedge CLK) begin
      if (mem_we === 1'b1) begin
         wAddr.push_back(int'(mem_addr));
         wData.push_back(int'(mem_wdata));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearLog();
      wAddr.delete();
      wData.delete();
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic newLoad();
      csumAcc = 8'd0;
      pulseStart();
   endtask

   // Offer one byte, wait (bounded) for acceptance, then idle `gap` cycles.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int n;
      byte_in = b;
      byte_valid = 1'b1;
      n = 0;
      while (1) begin
         @(negedge CLK);
         if (byte_ready === 1'b1) break;
         n++;
         if (n > 40) break;
      end
      if (n > 40) check("byte accept timeout", 32'(n), 32'd0);
      @(posedge CLK); #1;
      byte_valid = 1'b0;
      csumAcc = csumAcc ^ b;
      repeat (gap) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic finishCsum(input int gap);
`ifdef INST_LOADER_CHECKSUM_EN
      sendByte(csumAcc, gap);
`else
      if (gap < 0) sendByte(8'd0, 0);
`endif
   endtask

   task automatic waitEnd(input string tag);
      int n;
      n = 0;
      while (n <= 60) begin
         @(negedge CLK);
         if (done === 1'b1 || error === 1'b1) break;
         n++;
      end
      if (n > 60) check({tag, " end timeout"}, 32'(n), 32'd0);
      @(posedge CLK); #1;
   endtask

   task automatic sendTest2(input int gap);
      sendByte(8'h03, gap); sendByte(8'h00, gap);
      sendByte(8'h12, gap); sendByte(8'h00, gap);
      sendByte(8'h34, gap); sendByte(8'h01, gap);
      sendByte(8'hFF, gap); sendByte(8'h00, gap);
      finishCsum(gap);
   endtask

   task automatic checkTest2Log(input string tag);
      check({tag, " nwrites"}, 32'(wAddr.size()), 32'd3);
      check({tag, " w0"}, {wAddr[0][15:0], wData[0][15:0]}, {16'h0, 16'h012});
      check({tag, " w1"}, {wAddr[1][15:0], wData[1][15:0]}, {16'h1, 16'h134});
      check({tag, " w2"}, {wAddr[2][15:0], wData[2][15:0]}, {16'h2, 16'h0FF});
   endtask

   initial begin
      // 1: reset state
      #3;
      check("reset outputs", {byte_ready, mem_we, 4'(mem_addr), mem_wdata, busy, done, error, cpu_hold}, 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      repeat (3) begin @(posedge CLK); end
      #1;
      check("idle after release", {byte_ready, busy, done, error}, 32'd0);

      // 2: three-word load, write latency and held outputs
      clearLog();
      newLoad();
      check("t2 busy after start", {busy, cpu_hold, byte_ready}, 32'b111);
      sendByte(8'h03, 0); sendByte(8'h00, 0);
      sendByte(8'h12, 0); sendByte(8'h00, 0);
      @(negedge CLK);
      check("t2 write latency", {mem_we, 4'(mem_addr), mem_wdata}, {1'b1, 4'h0, 9'h012});
      @(posedge CLK); #1;
      sendByte(8'h34, 0); sendByte(8'h01, 0);
      sendByte(8'hFF, 0); sendByte(8'h00, 0);
      finishCsum(0);
      waitEnd("t2");
      checkTest2Log("t2");
      check("t2 status", {done, error, busy, cpu_hold}, 32'b1000);
      check("t2 held addr/data", {mem_we, 4'(mem_addr), mem_wdata}, {1'b0, 4'h2, 9'h0FF});

      // 3: zero count
      clearLog();
      newLoad();
      sendByte(8'h00, 0); sendByte(8'h00, 0);
      waitEnd("t3");
      check("t3 status", {done, error, busy, byte_ready}, 32'b1000);
      check("t3 no writes", 32'(wAddr.size()), 32'd0);

      // 4: bad hi byte, error cleared by start, start ignored while busy
      clearLog();
      newLoad();
      sendByte(8'h01, 0); sendByte(8'h00, 0);
      sendByte(8'h55, 0); sendByte(8'h02, 0);
      waitEnd("t4");
      check("t4 status", {done, error, busy, byte_ready}, 32'b0100);
      check("t4 no writes", 32'(wAddr.size()), 32'd0);
      newLoad();
      check("t4 start clears", {done, error, busy}, 32'b001);
      sendByte(8'h01, 0); sendByte(8'h00, 0);
      pulseStart();
      sendByte(8'hAA, 0); sendByte(8'h01, 0);
      finishCsum(0);
      waitEnd("t4b");
      check("t4b status", {done, error}, 32'b10);
      check("t4b nwrites", 32'(wAddr.size()), 32'd1);
      check("t4b w0", {wAddr[0][15:0], wData[0][15:0]}, {16'h0, 16'h1AA});

      // 5: source stalls, then reset during a write
      clearLog();
      newLoad();
      sendTest2(1);
      waitEnd("t5");
      checkTest2Log("t5");
      check("t5 status", {done, error}, 32'b10);
      clearLog();
      newLoad();
      sendByte(8'h03, 0); sendByte(8'h00, 0);
      sendByte(8'h12, 0); sendByte(8'h00, 0);
      sendByte(8'h34, 0); sendByte(8'h01, 0);
      check("t5 we before reset", 32'(mem_we), 32'd1);
      RESET_N = 1'b0;
      #1;
      check("t5 async reset", {mem_we, busy, cpu_hold, byte_ready, 4'(mem_addr)}, 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      byte_in = 8'hFF;
      byte_valid = 1'b1;
      repeat (4) begin @(posedge CLK); end
      #1;
      byte_valid = 1'b0;
      check("t5 idle after reset", {byte_ready, busy, done, error}, 32'd0);
      check("t5 nwrites", 32'(wAddr.size()), 32'd1);

      // 6: capacity limit for IW=4 (16 words legal, 17 and 256 rejected)
      clearLog();
      newLoad();
      sendByte(8'h11, 0); sendByte(8'h00, 0);
      waitEnd("t6a");
      check("t6 count17 error", {done, error}, 32'b01);
      newLoad();
      sendByte(8'h00, 0); sendByte(8'h01, 0);
      waitEnd("t6b");
      check("t6 count256 error", {done, error}, 32'b01);
      newLoad();
      sendByte(8'h10, 0); sendByte(8'h00, 0);
      for (int i = 0; i < 16; i++) begin
         sendByte(8'(i * 17 + 3), 0);
         sendByte(8'(i & 1), 0);
      end
      finishCsum(0);
      waitEnd("t6c");
      check("t6 count16 done", {done, error}, 32'b10);
      check("t6 nwrites", 32'(wAddr.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t6 w%0d", i), {wAddr[i][15:0], wData[i][15:0]},
               {16'(i), 7'd0, 1'(i & 1), 8'(i * 17 + 3)});
      end

`ifdef INST_LOADER_CHECKSUM_EN
      // 7: checksum accept and reject
      clearLog();
      newLoad();
      sendByte(8'h01, 0); sendByte(8'h00, 0);
      sendByte(8'hAA, 0); sendByte(8'h01, 0);
      sendByte(8'hAA, 0);
      waitEnd("t7a");
      check("t7 good csum", {done, error}, 32'b10);
      newLoad();
      sendByte(8'h01, 0); sendByte(8'h00, 0);
      sendByte(8'hAA, 0); sendByte(8'h01, 0);
      sendByte(8'hAB, 0);
      waitEnd("t7b");
      check("t7 bad csum", {done, error}, 32'b01);
      check("t7 nwrites", 32'(wAddr.size()), 32'd2);
      check("t7 w kept", {wAddr[1][15:0], wData[1][15:0]}, {16'h0, 16'h1AA});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
